countup_stopwatch: RTL and testbench

- Elapsed-time stopwatch for game rounds; counts seconds up from 00 to LIMIT in two BCD digits and drives two active-low seven-segment digits.
- Counterpart of the round countdown timer: counts up instead of down, asserts flag on reaching LIMIT, and supports start/pause/clear control from the game controller.
- Contains its own one-second prescaler, so it runs from the system clock alone.

---
 rtl/countup_stopwatch_pkg.sv | 33 +++
 rtl/bcd_seg7_decoder.sv | 27 ++
 rtl/countup_stopwatch.sv | 132 +++++++++++++
 tb/tb_countup_stopwatch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/countup_stopwatch_pkg.sv
// rtl/countup_stopwatch_pkg.sv - shared types and constants for the count-up stopwatch
// State encoding, active-low seven-segment patterns {g,f,e,d,c,b,a}, and LIMIT-to-BCD helper.
package countup_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {tens, ones}; callers keep value within 0..99.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// rtl/bcd_seg7_decoder.sv - 4-bit BCD digit to active-low seven-segment pattern
// Codes above 9 blank the digit.
module bcd_seg7_decoder
  import countup_stopwatch_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countup_stopwatch.sv
// rtl/countup_stopwatch.sv - two-digit BCD count-up stopwatch with start/pause/clear
// Counts one second per CLK_HZ cumulative RUN cycles up to LIMIT, then holds with flag set.
module countup_stopwatch
  import countup_stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned LIMIT  = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [6:0] out1,
  output logic [6:0] out2,
  output logic       flag,
  output logic       running
);

  localparam int unsigned   PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [7:0]    LIMIT_BCD = to_bcd(LIMIT);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic          r_start_q;
  logic          r_pause_q;

  state_t        w_state_next;
  logic [PW-1:0] w_presc_next;
  logic [3:0]    w_ones_next;
  logic [3:0]    w_tens_next;
  logic [3:0]    w_ones_inc;
  logic [3:0]    w_tens_inc;
  logic          w_start_edge;
  logic          w_pause_edge;
  logic          w_tick;

  assign w_start_edge = start & ~r_start_q;
  assign w_pause_edge = pause & ~r_pause_q;
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_ones_inc   = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
  assign w_tens_inc   = (r_ones == 4'd9) ? r_tens + 4'd1 : r_tens;

  // Edge registers load 1 in reset so inputs held high across release do not fire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_ones    <= '0;
      r_tens    <= '0;
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_ones    <= w_ones_next;
      r_tens    <= w_tens_next;
      r_start_q <= start;
      r_pause_q <= pause;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_ones_next  = r_ones;
    w_tens_next  = r_tens;
    if (clear) begin
      w_state_next = IDLE;
      w_presc_next = '0;
      w_ones_next  = '0;
      w_tens_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_presc_next = '0;
          w_ones_next  = '0;
          w_tens_next  = '0;
          if (w_start_edge) w_state_next = RUN;
        end
        RUN: begin
          // A pause edge wins over a coincident tick; the prescaler keeps its value.
          if (w_pause_edge) begin
            w_state_next = PAUSE;
          end else if (w_tick) begin
            w_presc_next = '0;
            w_ones_next  = w_ones_inc;
            w_tens_next  = w_tens_inc;
            if ({w_tens_inc, w_ones_inc} == LIMIT_BCD) w_state_next = DONE;
          end else begin
            w_presc_next = r_presc + PRESC_ONE;
          end
        end
        PAUSE: begin
          if (w_pause_edge) w_state_next = RUN;
        end
        DONE: begin
          w_presc_next = '0;
          if (w_start_edge) begin
            w_state_next = RUN;
            w_ones_next  = '0;
            w_tens_next  = '0;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_presc_next = '0;
          w_ones_next  = '0;
          w_tens_next  = '0;
        end
      endcase
    end
  end

  assign running = (r_state == RUN);
  assign flag    = (r_state == DONE);

  bcd_seg7_decoder u_dec_ones (
    .i_digit (r_ones),
    .o_seg   (out1)
  );

  bcd_seg7_decoder u_dec_tens (
    .i_digit (r_tens),
    .o_seg   (out2)
  );

endmodule

// File: tb/tb_countup_stopwatch.sv
// tb/tb_countup_stopwatch.sv - directed self-checking bench for countup_stopwatch
// Runs with CLK_HZ=4, LIMIT=12; observes {out2,out1,flag,running} one unit after each rising edge.
module tb_countup_stopwatch;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] out1;
  logic [6:0] out2;
  logic       flag;
  logic       running;
  logic [15:0] w_obs;
  logic [15:0] exp_v;
  int errors = 0;
  int checks = 0;

  countup_stopwatch #(.CLK_HZ(4), .LIMIT(12)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .out1    (out1),
    .out2    (out2),
    .flag    (flag),
    .running (running)
  );

  always #5 clock = ~clock;

  assign w_obs = {out2, out1, flag, running};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] expv(input int v, input logic f, input logic r);
    return {seg(v / 10), seg(v % 10), f, r};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start = 0; pause = 0; clear = 0; reset = 0;
    cyc(2);
    reset = 1;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1; cyc(1); start = 0;
  endtask

  task automatic pulse_pause();
    pause = 1; cyc(1); pause = 0;
  endtask

  task automatic test_reset();
    start = 1; pause = 0; clear = 0; reset = 0;
    cyc(2);
    exp_v = expv(0, 1'b0, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL reset_state: got %b expected %b", w_obs, exp_v); end
    reset = 1;
    cyc(6);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL reset_held_start: got %b expected %b", w_obs, exp_v); end
    start = 0;
    cyc(1);
  endtask

  task automatic test_count();
    do_reset();
    pulse_start();
    exp_v = expv(0, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL count_start: got %b expected %b", w_obs, exp_v); end
    for (int k = 1; k <= 10; k++) begin
      cyc(3);
      exp_v = expv(k - 1, 1'b0, 1'b1);
      checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL count_hold_%0d: got %b expected %b", k, w_obs, exp_v); end
      cyc(1);
      exp_v = expv(k, 1'b0, 1'b1);
      checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL count_step_%0d: got %b expected %b", k, w_obs, exp_v); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_start();
    cyc(6);
    exp_v = expv(1, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_before: got %b expected %b", w_obs, exp_v); end
    pulse_pause();
    exp_v = expv(1, 1'b0, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_enter: got %b expected %b", w_obs, exp_v); end
    cyc(20);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_frozen: got %b expected %b", w_obs, exp_v); end
    pulse_pause();
    exp_v = expv(1, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_resume: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_partial: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    exp_v = expv(2, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL pause_advance: got %b expected %b", w_obs, exp_v); end
  endtask

  task automatic test_done();
    do_reset();
    pulse_start();
    cyc(47);
    exp_v = expv(11, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_before: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    exp_v = expv(12, 1'b1, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_reach: got %b expected %b", w_obs, exp_v); end
    cyc(20);
    pulse_pause();
    cyc(2);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_hold: got %b expected %b", w_obs, exp_v); end
    pulse_start();
    exp_v = expv(0, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_restart: got %b expected %b", w_obs, exp_v); end
    cyc(3);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_restart_hold: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    exp_v = expv(1, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL done_restart_step: got %b expected %b", w_obs, exp_v); end
  endtask

  task automatic test_clear_start();
    do_reset();
    pulse_start();
    cyc(5);
    clear = 1; start = 1;
    cyc(1);
    clear = 0;
    exp_v = expv(0, 1'b0, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL clear_start: got %b expected %b", w_obs, exp_v); end
    cyc(6);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL clear_no_restart: got %b expected %b", w_obs, exp_v); end
    start = 0;
    cyc(1);
  endtask

  task automatic test_pause_on_tick();
    do_reset();
    pulse_start();
    cyc(3);
    pulse_pause();
    exp_v = expv(0, 1'b0, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL tickpause_discard: got %b expected %b", w_obs, exp_v); end
    cyc(3);
    pulse_pause();
    exp_v = expv(0, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL tickpause_resume: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    exp_v = expv(1, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL tickpause_deferred: got %b expected %b", w_obs, exp_v); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    pulse_start();
    cyc(29);
    exp_v = expv(7, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL midreset_before: got %b expected %b", w_obs, exp_v); end
    reset = 0;
    cyc(1);
    exp_v = expv(0, 1'b0, 1'b0);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL midreset_clear: got %b expected %b", w_obs, exp_v); end
    reset = 1;
    cyc(1);
    pulse_start();
    cyc(3);
    exp_v = expv(0, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL midreset_presc: got %b expected %b", w_obs, exp_v); end
    cyc(1);
    exp_v = expv(1, 1'b0, 1'b1);
    checks++;
    if (w_obs !== exp_v) begin errors++; $display("FAIL midreset_step: got %b expected %b", w_obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_done();
    test_clear_start();
    test_pause_on_tick();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
